result_bcd_display: RTL and testbench
=====================================

// Module: result_bcd_display
// PURPOSE
//  Downstream consumer of the polynomial datapath's DataResult/ResultValid pair.
//  - Captures each new result on the rising edge of ResultValid.
//  - Converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine.
//  - Drives active-low 7-segment digits for the board HEX displays.
//  - Holds one pending result so back-to-back results are not lost.
// PARAMETERS
//  DATA_W        8  width of DataResult (unsigned)
//  DIGITS        3  BCD digits produced; must satisfy 10**DIGITS > 2**DATA_W - 1
//  BLANK_LEADING 1  1 = leading-zero digits show blank (7'h7F); the LS digit is never blanked
// PORTS
//  Clock        in   1          system clock, all state on posedge
//  Reset        in   1          asynchronous, active-high; clears all state
//  DataResult   in   DATA_W     result value from datapath
//  ResultValid  in   1          level; high while the result is presentable
//  Busy         out  1          conversion in progress (state != S_IDLE)
//  BcdValid     out  1          one-cycle pulse: Bcd/HEX updated
//  Bcd          out  4*DIGITS   packed BCD, digit 0 in [3:0]
//  HexSeg       out  7*DIGITS   active-low segments {g..a}, digit 0 in [6:0]
// BEHAVIOUR
//  Reset, async, active-high:
//   - Busy=0, BcdValid=0, Bcd=0.
//   - HexSeg shows "0" in digit 0; other digits blank if BLANK_LEADING, else "0".
//   - rv_q=0, pending empty, state S_IDLE. Reset mid-conversion discards all work.
//  Edge detect:
//   - rv_q <= ResultValid each cycle; rise = ResultValid & ~rv_q.
//   - A level held high produces exactly one capture.
//  FSM states S_IDLE, S_SHIFT, S_DONE:
//   - S_IDLE: on rise, bin <= DataResult, bcd <= 0, cnt <= 0 -> S_SHIFT.
//     If the pending slot is full, load from the pending slot instead and clear it.
//   - S_SHIFT: each cycle, add 3 to every bcd nibble >= 5, then shift {bcd,bin} left 1.
//     cnt++. After DATA_W shifts (cnt==DATA_W-1) -> S_DONE.
//   - S_DONE: Bcd <= bcd, HexSeg updated, BcdValid <= 1 for one cycle.
//     Then S_SHIFT if pending is full (loading it), else S_IDLE.
//  Latency:
//   - Rise sampled at edge E -> Bcd/BcdValid update at edge E+DATA_W+1.
//   - BcdValid is high exactly 1 cycle.
//  Pending slot (depth 1):
//   - A rise while Busy stores DataResult in the slot.
//   - A second rise while the slot is full overwrites it (newest wins); no error flag.
//   - Rise in S_DONE with an empty slot: goes to the slot, consumed on the same exit.
//   - Rise in S_IDLE is taken directly; the slot stays untouched.
//  Outputs:
//   - Bcd and HexSeg hold their last value until the next S_DONE; never show partial sums.
//  Arithmetic:
//   - Unsigned only.
//   - Nibble add-3 is 4-bit, with no carry out (nibble <= 9 pre-add guaranteed).
//   - cnt width $clog2(DATA_W)+1.
// STRUCTURE
//  Package result_display_pkg:
//   - disp_state_t enum {S_IDLE,S_SHIFT,S_DONE}.
//   - SEG_BLANK = 7'h7F.
//   - Active-low digit table constants for 0-9.
//  Sub-module seg7_decoder:
//   - Combinational; 4-bit BCD + blank -> 7-bit active-low segments.
//   - Instantiated DIGITS times via generate.
//  Top holds the FSM, edge detect, pending slot and double-dabble registers.
// TESTING
//  1. Reset asserted mid-S_SHIFT (DataResult=200)
//     -> outputs return to reset values immediately; no BcdValid afterwards.
//  2. DataResult=8'd37, ResultValid 0->1
//     -> 9 edges later BcdValid pulse; Bcd=12'h037.
//     HexSeg: digit2 blank, digit1 "3" (7'b0110000), digit0 "7" (7'b1111000).
//  3. DataResult=8'd255 -> Bcd=12'h255; DataResult=8'd0 -> Bcd=12'h000.
//     For 0, only digit0 is lit, showing "0" (7'b1000000).
//  4. ResultValid held high 50 cycles -> exactly one BcdValid pulse.
//  5. Rise with 100, then 4 cycles later rise with 42 (while Busy)
//     -> BcdValid for 12'h100, then a second BcdValid 9 cycles later with 12'h042.
//  6. Three rises during one conversion (10, 20, 30)
//     -> BcdValid for 10, then for 30 only (20 overwritten).
//  7. Exhaustive sweep 0..255, each followed by a rise
//     -> every Bcd matches a reference decimal conversion.

Source files
------------

// File: rtl/result_display_pkg.sv
// Shared types and 7-segment constants for the result BCD display.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package result_display_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } disp_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

endpackage

// File: rtl/result_bcd_display_seg7_decoder.sv
// One BCD digit to active-low 7-segment pattern, with forced blanking.
// Non-decimal codes also show blank.
module seg7_decoder
    import result_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/result_bcd_display.sv
// Captures datapath results, converts them to BCD by double-dabble
// and drives the HEX displays; one pending result is buffered.
module result_bcd_display
    import result_display_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int DIGITS        = 3,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATA_W-1:0]     DataResult,
    input  logic                  ResultValid,
    output logic                  Busy,
    output logic                  BcdValid,
    output logic [4*DIGITS-1:0]   Bcd,
    output logic [7*DIGITS-1:0]   HexSeg
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam int BCD_W = 4 * DIGITS;

    disp_state_t        state_q;
    logic               rv_q;
    logic [DATA_W-1:0]  pend_q;
    logic               pend_full_q;
    logic [DATA_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, adj;
    logic [CNT_W-1:0]   cnt_q;
    logic [BCD_W-1:0]   bcd_out_q;
    logic               valid_q;
    logic               rise;
    logic [DIGITS-1:0]  lead;
    logic               lead_run;

    assign rise     = ResultValid & ~rv_q;
    assign Busy     = (state_q != S_IDLE);
    assign BcdValid = valid_q;
    assign Bcd      = bcd_out_q;

    // One double-dabble step: correct nibbles >= 5, then shift in next bit.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        {bcd_d, bin_d} = {adj, bin_q} << 1;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            rv_q        <= 1'b0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            bcd_out_q   <= '0;
            valid_q     <= 1'b0;
        end else begin
            rv_q    <= ResultValid;
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        state_q <= S_SHIFT;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        if (pend_full_q) begin
                            bin_q       <= pend_q;
                            pend_full_q <= 1'b0;
                        end else begin
                            bin_q <= DataResult;
                        end
                    end
                end
                S_SHIFT: begin
                    if (rise) begin
                        pend_q      <= DataResult;
                        pend_full_q <= 1'b1;
                    end
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1))
                        state_q <= S_DONE;
                end
                S_DONE: begin
                    bcd_out_q <= bcd_q;
                    valid_q   <= 1'b1;
                    // A rise seen here is newer than any slot content.
                    if (rise || pend_full_q) begin
                        state_q     <= S_SHIFT;
                        bcd_q       <= '0;
                        cnt_q       <= '0;
                        bin_q       <= rise ? DataResult : pend_q;
                        pend_full_q <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        lead     = '0;
        lead_run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lead_run = lead_run & (bcd_out_q[4*i +: 4] == 4'd0);
            lead[i]  = lead_run & (BLANK_LEADING != 0);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        seg7_decoder u_dec (
            .bcd_i   (bcd_out_q[4*g +: 4]),
            .blank_i (lead[g]),
            .seg_o   (HexSeg[7*g +: 7])
        );
    end

endmodule

// File: tb/tb_result_bcd_display.sv
// Self-checking bench for result_bcd_display: vector table,
// multi-cycle corner sequences and a full 0..255 sweep.
module tb_result_bcd_display;

    localparam int DATA_W = 8;
    localparam int DIGITS = 3;

    logic                 Clock = 1'b0;
    logic                 Reset;
    logic [DATA_W-1:0]    DataResult;
    logic                 ResultValid;
    logic                 Busy;
    logic                 BcdValid;
    logic [4*DIGITS-1:0]  Bcd;
    logic [7*DIGITS-1:0]  HexSeg;

    result_bcd_display #(
        .DATA_W(DATA_W), .DIGITS(DIGITS), .BLANK_LEADING(1)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .DataResult  (DataResult),
        .ResultValid (ResultValid),
        .Busy        (Busy),
        .BcdValid    (BcdValid),
        .Bcd         (Bcd),
        .HexSeg      (HexSeg)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [11:0] bcd;
        logic [20:0] hex;
    } exp_t;

    typedef struct {
        logic [7:0]  data;
        logic [11:0] bcd;
        logic [20:0] hex;
    } vec_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int last_cyc = 0;
    int prev_cyc = 0;
    int t_drive = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic exp_t model(input int v);
        exp_t e;
        int d2, d1, d0;
        logic [6:0] s2, s1;
        d2 = v / 100;
        d1 = (v / 10) % 10;
        d0 = v % 10;
        s2 = (d2 == 0) ? 7'h7F : seg_of(d2);
        s1 = (d2 == 0 && d1 == 0) ? 7'h7F : seg_of(d1);
        e.bcd = {d2[3:0], d1[3:0], d0[3:0]};
        e.hex = {s2, s1, seg_of(d0)};
        return e;
    endfunction

    // Scoreboard: every BcdValid pulse must match the oldest expectation.
    always @(negedge Clock) begin
        if (!Reset && BcdValid) begin
            pulse_cnt++;
            prev_cyc = last_cyc;
            last_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("bcd", 32'(Bcd), 32'(e.bcd));
                check("hexseg", 32'(HexSeg), 32'(e.hex));
            end
        end
    end

    task automatic send(input logic [7:0] v);
        @(posedge Clock); #1;
        DataResult  = v;
        ResultValid = 1'b1;
        t_drive     = cyc;
        @(posedge Clock); #1;
        ResultValid = 1'b0;
    endtask

    task automatic wait_pulses(input int target, input string name);
        int k;
        for (k = 0; k < 200 && pulse_cnt < target; k++)
            @(posedge Clock);
        @(negedge Clock);
        if (pulse_cnt < target)
            check(name, 32'(pulse_cnt), 32'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(Busy), 32'd0);
        check({tag, "_valid"}, 32'(BcdValid), 32'd0);
        check({tag, "_bcd"}, 32'(Bcd), 32'd0);
        check({tag, "_hex"}, 32'(HexSeg), 32'({7'h7F, 7'h7F, 7'h40}));
    endtask

    vec_t vecs[7];

    initial begin
        int base;
        vecs[0] = '{8'd37,  12'h037, {7'h7F, 7'h30, 7'h78}};
        vecs[1] = '{8'd255, 12'h255, {7'h24, 7'h12, 7'h12}};
        vecs[2] = '{8'd0,   12'h000, {7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{8'd100, 12'h100, {7'h79, 7'h40, 7'h40}};
        vecs[4] = '{8'd5,   12'h005, {7'h7F, 7'h7F, 7'h12}};
        vecs[5] = '{8'd90,  12'h090, {7'h7F, 7'h10, 7'h40}};
        vecs[6] = '{8'd209, 12'h209, {7'h24, 7'h40, 7'h10}};

        Reset       = 1'b1;
        DataResult  = '0;
        ResultValid = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        check_reset_outputs("rst_init");
        Reset = 1'b0;

        // Reset in the middle of a conversion discards it.
        send(8'd200);
        sb.push_back(model(200));
        repeat (2) @(posedge Clock);
        #3;
        check("midshift_busy", 32'(Busy), 32'd1);
        Reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        sb.delete();
        @(posedge Clock); #2;
        Reset = 1'b0;
        base = pulse_cnt;
        repeat (20) @(posedge Clock);
        check("no_pulse_after_rst", 32'(pulse_cnt - base), 32'd0);

        // Vector table with latency check.
        foreach (vecs[i]) begin
            exp_t e;
            base = pulse_cnt;
            e.bcd = vecs[i].bcd;
            e.hex = vecs[i].hex;
            sb.push_back(e);
            send(vecs[i].data);
            wait_pulses(base + 1, "vec_timeout");
            check("latency", 32'(last_cyc - t_drive), 32'(DATA_W + 2));
        end

        // Level held high produces one capture.
        base = pulse_cnt;
        sb.push_back(model(77));
        @(posedge Clock); #1;
        DataResult  = 8'd77;
        ResultValid = 1'b1;
        repeat (50) @(posedge Clock);
        #1;
        ResultValid = 1'b0;
        repeat (15) @(posedge Clock);
        check("held_level_pulses", 32'(pulse_cnt - base), 32'd1);

        // Second result arrives while busy.
        base = pulse_cnt;
        sb.push_back(model(100));
        sb.push_back(model(42));
        send(8'd100);
        repeat (2) @(posedge Clock);
        send(8'd42);
        wait_pulses(base + 2, "pending_timeout");
        check("pending_gap", 32'(last_cyc - prev_cyc), 32'd9);

        // Newest pending result wins.
        base = pulse_cnt;
        sb.push_back(model(10));
        sb.push_back(model(30));
        send(8'd10);
        send(8'd20);
        send(8'd30);
        wait_pulses(base + 2, "overwrite_timeout");
        repeat (15) @(posedge Clock);
        check("overwrite_pulses", 32'(pulse_cnt - base), 32'd2);

        // Full sweep.
        for (int v = 0; v < 256; v++) begin
            base = pulse_cnt;
            sb.push_back(model(v));
            send(8'(v));
            wait_pulses(base + 1, "sweep_timeout");
        end
        repeat (5) @(posedge Clock);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
